// File: rtl/blit_pkg.sv
// Shared definitions for the blitter command path.
package blit_pkg;

  localparam int BLIT_CMD_W       = 96;
  localparam int BLIT_QUEUE_DEPTH = 32;

  // One blitter command as written by the register block.
  typedef struct packed {
    logic [31:0] opcode;
    logic [31:0] arg1;
    logic [31:0] arg2;
  } blit_cmd_t;

endpackage

// File: rtl/blit_cmd_ram.sv
// DEPTH x WIDTH simple dual-port command store.
// Writes are synchronous. Reads are registered behind a read enable.
// The read data register is the queue's output stage.
module blit_cmd_ram
  import blit_pkg::*;
#(
  parameter int DEPTH = BLIT_QUEUE_DEPTH,
  parameter int WIDTH = BLIT_CMD_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array write port; no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port.
  // It only changes on an explicit load, so the presented command holds between loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/blit_cmd_queue.sv
// Command queue between the register block and the blitter engine.
// Entries pass through the RAM into its read register, which presents the head
// first-word-fall-through. Occupancy counts RAM entries plus the presented head.
module blit_cmd_queue
  import blit_pkg::*;
#(
  parameter int DEPTH = BLIT_QUEUE_DEPTH,
  parameter int WIDTH = BLIT_CMD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic [7:0]       slots_free,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  input  logic             flush,
  input  logic             clear_stats,
  output logic             overflow,
  output logic [7:0]       high_water,
  output logic [7:0]       level
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    slots_q, slots_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    high_water_q, high_water_d;

  logic          pop_s, push_s, drop_s, load_s;
  logic [7:0]    stored_s, hw_base_s;

  // Handshake decode and next-state for pointers, occupancy, head valid and stats.
  always_comb begin
    pop_s  = valid_q & rd_ready & ~flush;
    // A full queue still takes a push when the head leaves on the same edge.
    push_s = wr_valid & ~flush & ((count_q < DEPTH_C) | pop_s);
    // Pushes swallowed by flush are not overflows.
    drop_s = wr_valid & ~flush & ~push_s;
    // Entries still in the RAM were all written on an earlier edge, so they are readable now.
    stored_s = count_q - {7'd0, valid_q};
    load_s   = ~flush & (stored_s != 8'd0) & (~valid_q | pop_s);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 8'd0;
      valid_d  = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {7'd0, push_s} - {7'd0, pop_s};
      if (load_s) begin
        valid_d = 1'b1;
      end else if (pop_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    slots_d      = DEPTH_C - count_d;
    hw_base_s    = clear_stats ? 8'd0 : high_water_q;
    high_water_d = (count_d > hw_base_s) ? count_d : hw_base_s;
    overflow_d   = (clear_stats ? 1'b0 : overflow_q) | drop_s;
  end

  // State registers; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 8'd0;
      slots_q      <= DEPTH_C;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      high_water_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      slots_q      <= slots_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      high_water_q <= high_water_d;
    end
  end

  blit_cmd_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (push_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (load_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign rd_valid   = valid_q;
  assign level      = count_q;
  assign slots_free = slots_q;
  assign overflow   = overflow_q;
  assign high_water = high_water_q;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Self-checking bench for blit_cmd_queue.
// A queue-based reference model is compared on every cycle.
// Directed sequences add hand-computed expectations.
module tb_blit_cmd_queue;

  localparam int DEPTH = 32;
  localparam int W     = 96;

  logic          clock = 1'b0;
  logic          reset, wr_valid, rd_ready, flush, clear_stats;
  logic [W-1:0]  wr_data;
  logic [7:0]    slots_free, high_water, level;
  logic          rd_valid, overflow;
  logic [W-1:0]  rd_data;

  int checks = 0;
  int errors = 0;

  blit_cmd_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .slots_free  (slots_free),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .flush       (flush),
    .clear_stats (clear_stats),
    .overflow    (overflow),
    .high_water  (high_water),
    .level       (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry remembers the edge it was pushed on.
  // The head is visible once it was pushed on an earlier edge than the current one.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  ent_t         mq[$];
  int           edge_n = 0;
  bit           m_on = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_ovf = 1'b0;
  int           m_hw = 0;
  bit           m_pop, m_drop;
  int           m_n, m_hwb;
  bit           m_ovfb;

  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_hw    = 0;
      m_on    = 1'b1;
    end else if (m_on) begin
      m_hwb  = clear_stats ? 0 : m_hw;
      m_ovfb = clear_stats ? 1'b0 : m_ovf;
      m_drop = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        m_n   = mq.size();
        m_pop = m_valid && rd_ready;
        if (m_pop) void'(mq.pop_front());
        if (wr_valid) begin
          if (m_n < DEPTH || m_pop) mq.push_back('{d: wr_data, e: edge_n});
          else m_drop = 1'b1;
        end
      end
      m_valid = (mq.size() > 0) && (mq[0].e < edge_n);
      m_ovf   = m_ovfb | m_drop;
      m_hw    = (mq.size() > m_hwb) ? mq.size() : m_hwb;
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clock) begin
    if (m_on) begin
      chk("m_rd_valid", rd_valid, m_valid);
      chk("m_level", level, mq.size());
      chk("m_slots_free", slots_free, DEPTH - mq.size());
      chk("m_overflow", overflow, m_ovf);
      chk("m_high_water", high_water, m_hw);
      if (m_valid) chk("m_rd_data", rd_data, mq[0].d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit rr,
                     input bit fl = 1'b0, input bit cs = 1'b0, input bit rs = 1'b0);
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    flush = fl; clear_stats = cs; reset = rs;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_cmd();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  int max_lvl;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    flush = 1'b0; clear_stats = 1'b0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_slots_free", slots_free, 32);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_high_water", high_water, 0);

    // Three pushes, then drain A, B, C back to back.
    cyc(1, 96'h1, 0);
    cyc(1, 96'h2, 0);
    cyc(1, 96'h3, 0);
    chk("abc_level", level, 3);
    chk("abc_slots_free", slots_free, 29);
    chk("abc_head", rd_data, 96'h1);
    for (int i = 1; i <= 3; i++) begin
      chk("abc_drain_valid", rd_valid, 1);
      chk("abc_drain_data", rd_data, i);
      cyc(0, 0, 1);
    end
    chk("abc_empty_valid", rd_valid, 0);
    chk("abc_empty_slots", slots_free, 32);

    // Fill to 32, overflow with a 33rd, drain in order.
    for (int i = 1; i <= 32; i++) cyc(1, 96'd100 + i, 0);
    cyc(1, 96'd999, 0);
    chk("full_overflow", overflow, 1);
    chk("full_high_water", high_water, 32);
    chk("full_slots_free", slots_free, 0);
    chk("full_level", level, 32);
    for (int i = 1; i <= 32; i++) begin
      chk("full_drain_data", rd_data, 96'd100 + i);
      cyc(0, 0, 1);
    end
    chk("full_drain_level", level, 0);
    cyc(0, 0, 0, 0, 1);
    chk("clr_overflow", overflow, 0);
    chk("clr_high_water", high_water, 0);

    // Full queue, same-cycle push and pop.
    for (int i = 1; i <= 32; i++) cyc(1, 96'd200 + i, 0);
    cyc(1, 96'hABC, 1);
    chk("fpp_level", level, 32);
    chk("fpp_overflow", overflow, 0);
    for (int i = 2; i <= 33; i++) begin
      chk("fpp_drain_data", rd_data, (i == 33) ? 96'hABC : 96'd200 + i);
      cyc(0, 0, 1);
    end
    chk("fpp_drain_valid", rd_valid, 0);

    // Continuous push and pop with random opcodes.
    max_lvl = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1, rnd_cmd(), 1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    chk("stream_level_max", max_lvl, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);

    // Random mix: fill-heavy first, then drain-heavy, with occasional flush and clear.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd_cmd(),
          (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0);
    end
    cyc(0, 0, 0, 1, 1);

    // Flush with 5 queued and a simultaneous push, then a one-bubble refill.
    for (int i = 1; i <= 5; i++) cyc(1, 96'h300 + i, 0);
    cyc(1, 96'h555, 0, 1);
    chk("fl5_level", level, 0);
    chk("fl5_valid", rd_valid, 0);
    chk("fl5_overflow", overflow, 0);
    chk("fl5_high_water", high_water, 5);
    cyc(1, 96'h777, 0);
    chk("fl5_bubble_valid", rd_valid, 0);
    cyc(0, 0, 0);
    chk("fl5_refill_valid", rd_valid, 1);
    chk("fl5_refill_data", rd_data, 96'h777);
    cyc(0, 0, 1);

    // Flush of a full queue with a push: the swallowed push is not an overflow.
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 32; i++) cyc(1, 96'h500 + i, 0);
    cyc(1, 96'h666, 0, 1);
    chk("flf_overflow", overflow, 0);
    chk("flf_high_water", high_water, 32);
    chk("flf_level", level, 0);

    // Reset mid-drain.
    for (int i = 1; i <= 10; i++) cyc(1, 96'h400 + i, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 96'h999, 1, 0, 0, 1);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_rd_data", rd_data, 0);
    chk("mrst_level", level, 0);
    chk("mrst_slots_free", slots_free, 32);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_high_water", high_water, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk("mrst_no_stale", rd_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
